bcd_mod_counter: RTL

Parametrised multi-digit BCD modulo counter, the next generation of the board-level 00–24 BCD counter. It generalises digit count and terminal value, and adds:
- up/down counting
- count enable
- synchronous clear
- validated parallel load
- wrap and terminal-count flags for cascading

It is the counting core for clock, timer and scoreboard designs on the lab board. Board-pin mapping and display decoding are done in a separate wrapper.

---
 rtl/bcd_mod_counter.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/bcd_mod_counter.sv
// Multi-digit BCD modulo counter (0..MOD_MAX) with up/down, enable, clear,
// validated parallel load, and terminal-count / wrap flags for cascading.
module bcd_mod_counter #(
  parameter int DIGITS  = 2,
  parameter int MOD_MAX = 24
) (
  input  logic                ck,
  input  logic                rs_n,
  input  logic                clr,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  input  logic                en,
  input  logic                up,
  output logic [4*DIGITS-1:0] count,
  output logic                tc,
  output logic                wrap,
  output logic                load_err
);

  localparam int W = 4 * DIGITS;

  function automatic int pow10(input int n);
    int r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    int           t;
    r = '0;
    t = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  localparam logic [W-1:0] MOD_BCD = to_bcd(MOD_MAX);
  localparam logic [W-1:0] ZERO    = '0;

  generate
    if (DIGITS < 1 || DIGITS > 6) begin : g_bad_digits
      $error("bcd_mod_counter: DIGITS must be in 1..6");
    end
    if (MOD_MAX < 1 || MOD_MAX >= pow10(DIGITS)) begin : g_bad_mod
      $error("bcd_mod_counter: MOD_MAX must be in 1..10^DIGITS-1");
    end
  endgenerate

  logic [W-1:0] inc_val;
  logic [W-1:0] dec_val;
  logic         digits_ok;
  logic         load_ok;
  logic         at_max;
  logic         at_zero;
  logic [W-1:0] count_nxt;
  logic         wrap_nxt;
  logic         load_err_nxt;

  // Ripple carry: each digit only moves while every lower digit is rolling over.
  always_comb begin : inc_chain
    logic carry;
    inc_val = count;
    carry   = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (count[4*i +: 4] == 4'd9) begin
          inc_val[4*i +: 4] = 4'd0;
        end else begin
          inc_val[4*i +: 4] = count[4*i +: 4] + 4'd1;
          carry             = 1'b0;
        end
      end
    end
  end

  always_comb begin : dec_chain
    logic borrow;
    dec_val = count;
    borrow  = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (count[4*i +: 4] == 4'd0) begin
          dec_val[4*i +: 4] = 4'd9;
        end else begin
          dec_val[4*i +: 4] = count[4*i +: 4] - 4'd1;
          borrow            = 1'b0;
        end
      end
    end
  end

  always_comb begin
    digits_ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (load_val[4*i +: 4] > 4'd9) digits_ok = 1'b0;
    end
  end

  // With all digits legal, BCD ordering matches plain unsigned ordering.
  assign load_ok = digits_ok && (load_val <= MOD_BCD);
  assign at_max  = (count == MOD_BCD);
  assign at_zero = (count == ZERO);
  assign tc      = en & (up ? at_max : at_zero);

  always_comb begin
    count_nxt    = count;
    wrap_nxt     = 1'b0;
    load_err_nxt = 1'b0;
    if (clr) begin
      count_nxt = ZERO;
    end else if (load) begin
      if (load_ok) count_nxt = load_val;
      load_err_nxt = ~load_ok;
    end else if (en) begin
      if (up) begin
        count_nxt = at_max ? ZERO : inc_val;
        wrap_nxt  = at_max;
      end else begin
        count_nxt = at_zero ? MOD_BCD : dec_val;
        wrap_nxt  = at_zero;
      end
    end
  end

  always_ff @(posedge ck or negedge rs_n) begin
    if (!rs_n) begin
      count    <= ZERO;
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      count    <= count_nxt;
      wrap     <= wrap_nxt;
      load_err <= load_err_nxt;
    end
  end

endmodule
